// File: rtl/reg_file_wb_pkg.sv
// rtl/reg_file_wb_pkg.sv - shared register-file constants and state type
package reg_file_wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

endpackage

// File: rtl/reg_file_wb_if.sv
// rtl/reg_file_wb_if.sv - datapath-side register file bus
interface reg_file_wb_if #(
  parameter int DATA_W = reg_file_wb_pkg::DATA_W,
  parameter int ADDR_W = reg_file_wb_pkg::ADDR_W
) ();

  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              Ready;
  logic [ADDR_W-1:0] DbgAddr;
  logic [DATA_W-1:0] DbgData;

  modport master (
    output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, DbgAddr,
    input  ReadData1, ReadData2, Ready, DbgData
  );

  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, DbgAddr,
    output ReadData1, ReadData2, Ready, DbgData
  );

endinterface

// File: rtl/reg_file_wb_array.sv
// rtl/reg_file_wb_array.sv - unreset 2-read/1-write storage with debug read port
module reg_array_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [NREGS];

  // No reset here on purpose so the array maps onto RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1   = mem[raddr1];
  assign rdata2   = mem[raddr2];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/reg_file_wb.sv
// rtl/reg_file_wb.sv - register file with write-back staging, read bypass and clear sequencer
module reg_file_wb #(
  parameter int DATA_W = reg_file_wb_pkg::DATA_W,
  parameter int ADDR_W = reg_file_wb_pkg::ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_wb_if.slave bus
);
  import reg_file_wb_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              ready;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rd1;
  logic [DATA_W-1:0] arr_rd2;
  logic [DATA_W-1:0] arr_dbg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      ready    <= 1'b0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          wb_valid <= 1'b0;
          if (clr_cnt == LAST_IDX) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        RUN: begin
          if (bus.RegWrite && bus.WriteReg != ZERO_IDX) begin
            wb_valid <= 1'b1;
            wb_addr  <= bus.WriteReg;
            wb_data  <= bus.WriteData;
          end else begin
            wb_valid <= 1'b0;
          end
        end
        default: begin
          state <= CLEAR;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Gating with rst_n keeps a pending entry from committing on the reset edge.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = clr_cnt;
    arr_wdata = '0;
    if (rst_n) begin
      if (state == CLEAR) begin
        arr_we = 1'b1;
      end else begin
        arr_we    = wb_valid;
        arr_waddr = wb_addr;
        arr_wdata = wb_data;
      end
    end
  end

  reg_array_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk      (clk),
    .we       (arr_we),
    .waddr    (arr_waddr),
    .wdata    (arr_wdata),
    .raddr1   (bus.ReadReg1),
    .rdata1   (arr_rd1),
    .raddr2   (bus.ReadReg2),
    .rdata2   (arr_rd2),
    .dbg_addr (bus.DbgAddr),
    .dbg_data (arr_dbg)
  );

  function automatic logic [DATA_W-1:0] sel_read(
    input logic              run,
    input logic              use_bypass,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] arr_val
  );
    if (!run || addr == ZERO_IDX) begin
      return '0;
    end else if (use_bypass && wb_valid && wb_addr == addr) begin
      return wb_data;
    end else begin
      return arr_val;
    end
  endfunction

  logic run;
  assign run = (state == RUN);

  assign bus.ReadData1 = sel_read(run, BYPASS != 0, bus.ReadReg1, arr_rd1);
  assign bus.ReadData2 = sel_read(run, BYPASS != 0, bus.ReadReg2, arr_rd2);
  assign bus.DbgData   = sel_read(run, 1'b0, bus.DbgAddr, arr_dbg);
  assign bus.Ready     = ready;

endmodule
